// File: rtl/ajuste_botones_ctrl.sv
// ---------------------------------------------------------------------------
// ajuste_botones_ctrl
//
// Front end of the time-setting path. Four raw push-buttons are synchronised
// (2 flops), debounced (one counter per button) and edge-detected. The result
// drives the field selector EN and the one-cycle aumento/disminuye strobes
// that the hour, minute and second adjust counters consume. Each counter acts
// only when EN equals its own code.
//
// Optional feature macro: AUTOREPEAT_EN
//   defined   : a held up/down button auto-repeats after REP_DELAY cycles,
//               then every REP_RATE cycles until release.
//   undefined : exactly one strobe per press; no repeat logic is built.
//
// Parameters:
//   DEB_CYCLES  cycles a synchronised level must hold to change the debounced
//               state (minimum 2)
//   REP_DELAY   hold time before auto-repeat starts (AUTOREPEAT_EN only)
//   REP_RATE    cycles between auto-repeat strobes (AUTOREPEAT_EN only)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   ajuste_on  in   set mode active (synchronous level)
//   btn_up     in   raw button, asynchronous, active high
//   btn_down   in   raw button, asynchronous, active high
//   btn_left   in   raw button, asynchronous, active high
//   btn_right  in   raw button, asynchronous, active high
//   EN         out  field select: 0 hours, 1 minutes, 2 seconds, 3 none
//   aumento    out  one-cycle increment strobe
//   disminuye  out  one-cycle decrement strobe
//
// Latency: a raw level stable from edge k gives a strobe (or EN change) in
// the cycle after edge k+DEB_CYCLES+3 (2 sync + DEB_CYCLES debounce + edge
// register + output register).
// ---------------------------------------------------------------------------
module ajuste_botones_ctrl #(
  parameter int DEB_CYCLES = 1000,
  parameter int REP_DELAY  = 50000,
  parameter int REP_RATE   = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ajuste_on,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] EN,
  output logic       aumento,
  output logic       disminuye
);

  // Bit positions of the buttons inside the internal 4-bit vectors.
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  // Debounce counter only needs to reach DEB_CYCLES-1.
  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  // Elaboration guard on the parameter ranges.
  if (DEB_CYCLES < 2 || REP_DELAY < 1 || REP_RATE < 1) begin : g_param_check
    $error("ajuste_botones_ctrl: DEB_CYCLES >= 2, REP_DELAY >= 1, REP_RATE >= 1 required");
  end

  typedef enum logic [1:0] {
    HORA = 2'd0,
    MIN  = 2'd1,
    SEG  = 2'd2,
    NONE = 2'd3
  } field_t;

  // Next field to the right: HORA -> MIN -> SEG -> HORA.
  function automatic field_t field_fwd(input field_t f);
    field_t r;
    case (f)
      HORA:    r = MIN;
      MIN:     r = SEG;
      SEG:     r = HORA;
      default: r = NONE;
    endcase
    return r;
  endfunction

  // Next field to the left: HORA -> SEG -> MIN -> HORA.
  function automatic field_t field_back(input field_t f);
    field_t r;
    case (f)
      HORA:    r = SEG;
      MIN:     r = HORA;
      SEG:     r = MIN;
      default: r = NONE;
    endcase
    return r;
  endfunction

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [DW-1:0] deb_cnt [4];
  logic [3:0]    deb_d;
  logic [3:0]    press;

  field_t        state;
  field_t        state_next;
  logic          gate;
  logic          up_ok;
  logic          dn_ok;
  logic          rep_up;
  logic          rep_dn;
  logic          aum_next;
  logic          dis_next;

  assign raw = {btn_right, btn_left, btn_down, btn_up};
  assign EN  = state;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive cycles of disagreement, adopt the new level
  // once the count reaches DEB_CYCLES; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Rising-edge detect of the debounced states; press is a registered
  // one-cycle pulse, release edges are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_d <= 4'b0000;
      press <= 4'b0000;
    end else begin
      deb_d <= deb;
      press <= deb & ~deb_d;
    end
  end

  // Field selector next state and the press-strobe qualification.
  always_comb begin
    state_next = state;
    gate       = 1'b0;
    up_ok      = 1'b0;
    dn_ok      = 1'b0;
    if (!ajuste_on) begin
      state_next = NONE;
    end else if (state == NONE) begin
      state_next = HORA;
    end else if (press[BTN_RIGHT] && !press[BTN_LEFT]) begin
      state_next = field_fwd(state);
    end else if (press[BTN_LEFT] && !press[BTN_RIGHT]) begin
      state_next = field_back(state);
    end else begin
      state_next = state;
    end
    // Any left/right press (even a cancelled pair) drops a coinciding
    // up/down press, so a strobe never lands on an EN change.
    gate  = ajuste_on & (state != NONE) & ~press[BTN_LEFT] & ~press[BTN_RIGHT];
    // Holding the opposite button blocks a press; a simultaneous up/down
    // pair is blocked too because both debounced states are high then.
    up_ok = gate & press[BTN_UP]   & ~deb[BTN_DOWN] & ~press[BTN_DOWN];
    dn_ok = gate & press[BTN_DOWN] & ~deb[BTN_UP]   & ~press[BTN_UP];
  end

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

  logic          rep_active;
  logic          rep_dir;     // 0 = up, 1 = down
  logic          rep_first;   // still waiting out REP_DELAY
  logic [RW-1:0] rep_cnt;
  logic          rep_keep;
  logic          rep_hit;

  // Repeat timer keeps running only while the same button stays held in an
  // unchanged, active field.
  always_comb begin
    rep_keep = rep_active & ajuste_on & (state != NONE) & (state_next == state)
             & (rep_dir ? deb[BTN_DOWN] : deb[BTN_UP]);
    rep_hit  = rep_first ? (rep_cnt == DELAY_LAST) : (rep_cnt == RATE_LAST);
    rep_up   = rep_keep & rep_hit & ~rep_dir;
    rep_dn   = rep_keep & rep_hit & rep_dir;
  end

  // Repeat counter: armed by a press strobe, cleared on release, field
  // change or leaving set mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_active <= 1'b0;
      rep_dir    <= 1'b0;
      rep_first  <= 1'b0;
      rep_cnt    <= '0;
    end else if (up_ok || dn_ok) begin
      rep_active <= 1'b1;
      rep_dir    <= dn_ok;
      rep_first  <= 1'b1;
      rep_cnt    <= '0;
    end else if (rep_keep) begin
      if (rep_hit) begin
        rep_first <= 1'b0;
        rep_cnt   <= '0;
      end else begin
        rep_cnt   <= rep_cnt + RW'(1);
      end
    end else begin
      rep_active <= 1'b0;
      rep_first  <= 1'b0;
      rep_cnt    <= '0;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  // Strobe selection: repeat strobes obey the same exclusions as presses.
  always_comb begin
    aum_next = up_ok | (rep_up & gate & ~deb[BTN_DOWN]);
    dis_next = dn_ok | (rep_dn & gate & ~deb[BTN_UP]);
  end

  // Registered outputs: field selector and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= NONE;
      aumento   <= 1'b0;
      disminuye <= 1'b0;
    end else begin
      state     <= state_next;
      aumento   <= aum_next;
      disminuye <= dis_next;
    end
  end

endmodule

// File: tb/tb_ajuste_botones_ctrl.sv
// Self-checking bench for ajuste_botones_ctrl (DEB_CYCLES=4, REP_DELAY=20,
// REP_RATE=5). A behavioural model predicts EN/aumento/disminuye every cycle;
// directed sequences add literal expectations on latency and pulse counts.
module tb_ajuste_botones_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ajuste_on = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic [1:0] EN;
  logic       aumento;
  logic       disminuye;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cnt_up = 0;
  int cnt_dn = 0;

  ajuste_botones_ctrl #(.DEB_CYCLES(DEB), .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .clk(clk), .rst(rst), .ajuste_on(ajuste_on),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .EN(EN), .aumento(aumento), .disminuye(disminuye)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons as a vector: bit0 up, bit1 down, bit2 left, bit3 right.
  // hist[0] is the newest raw sample; a button's debounced level flips to v
  // when the DEB synchronised samples (raw delayed by two edges) all equal v.
  bit [3:0] hist [DEB+1];
  bit [3:0] m_deb = 4'b0;
  bit [3:0] rise1 = 4'b0;
  bit [3:0] rise2 = 4'b0;
  int       m_en = 3;
  bit       m_up = 1'b0;
  bit       m_dn = 1'b0;
  bit       r_act = 1'b0;
  bit       r_dn = 1'b0;
  int       r_t0 = 0;
  int       mcyc = 0;

  always @(posedge clk or posedge rst) begin
    bit [3:0] act, held, newdeb, rawv;
    int en_next, d;
    bit gate, up_ok, dn_ok, keep, rep, all1, all0;
    if (rst) begin
      for (int i = 0; i <= DEB; i++) hist[i] = 4'b0;
      m_deb = 4'b0; rise1 = 4'b0; rise2 = 4'b0;
      m_en = 3; m_up = 1'b0; m_dn = 1'b0;
      r_act = 1'b0; r_dn = 1'b0; r_t0 = 0;
    end else begin
      mcyc++;
      rawv = {btn_right, btn_left, btn_down, btn_up};
      act  = rise2;     // debounced rise two edges ago reaches the outputs now
      held = m_deb;
      if (!ajuste_on)                en_next = 3;
      else if (m_en == 3)            en_next = 0;
      else if (act[3] && !act[2])    en_next = (m_en + 1) % 3;
      else if (act[2] && !act[3])    en_next = (m_en + 2) % 3;
      else                           en_next = m_en;
      gate  = ajuste_on && m_en != 3 && !act[2] && !act[3];
      up_ok = gate && act[0] && !held[1];
      dn_ok = gate && act[1] && !held[0];
      rep   = 1'b0;
`ifdef AUTOREPEAT_EN
      keep = r_act && ajuste_on && m_en != 3 && en_next == m_en && held[r_dn ? 1 : 0];
      if (keep) begin
        d = mcyc - r_t0;
        if (d == RD || (d > RD && (d - RD) % RR == 0)) rep = 1'b1;
      end
      if (up_ok || dn_ok) begin
        r_act = 1'b1; r_dn = dn_ok; r_t0 = mcyc;
      end else if (!keep) begin
        r_act = 1'b0;
      end
`else
      keep = 1'b0;
      d = 0;
`endif
      m_up = up_ok || (rep && !r_dn && gate && !held[1]);
      m_dn = dn_ok || (rep &&  r_dn && gate && !held[0]);
      m_en = en_next;
      // debounce window: hist[1..DEB] are the synchronised samples
      newdeb = m_deb;
      for (int b = 0; b < 4; b++) begin
        all1 = 1'b1; all0 = 1'b1;
        for (int i = 1; i <= DEB; i++) begin
          if (!hist[i][b]) all1 = 1'b0;
          if (hist[i][b])  all0 = 1'b0;
        end
        if (all1) newdeb[b] = 1'b1;
        if (all0) newdeb[b] = 1'b0;
      end
      rise2 = rise1;
      rise1 = newdeb & ~m_deb;
      m_deb = newdeb;
      for (int i = DEB; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rawv;
    end
  end

  // Per-cycle comparison against the model, plus strobe pulse counters.
  always @(negedge clk) begin
    chk("EN", {30'd0, EN}, m_en);
    chk("aumento", {31'd0, aumento}, {31'd0, m_up});
    chk("disminuye", {31'd0, disminuye}, {31'd0, m_dn});
    if (aumento === 1'b1)   cnt_up++;
    if (disminuye === 1'b1) cnt_dn++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) step();
  endtask

  task automatic set_btn(input logic [3:0] m);
    {btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic tap(input logic [3:0] m, input int hold, input int gap);
    set_btn(m);
    step(hold);
    set_btn(4'b0000);
    step(gap);
  endtask

  int k;
  int u0, d0;
  int dur [4];
  logic [3:0] lvl;

  initial begin
    // 1. reset, mid-run reset pulse, entry into set mode
    #1 rst = 1'b1;
    step(3);
    chk("reset_en", {30'd0, EN}, 32'd3);
    chk("reset_aum", {31'd0, aumento}, 32'd0);
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    #1;
    chk("midrst_en", {30'd0, EN}, 32'd3);
    chk("midrst_dis", {31'd0, disminuye}, 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    ajuste_on = 1'b1;
    chk("pre_entry_en", {30'd0, EN}, 32'd3);
    step(1);
    chk("entry_en", {30'd0, EN}, 32'd0);

    // 2. right-press latency, wrap both ways
    set_btn(4'b1000);
    k = cyc + 1;
    wait_to(k + 6);
    chk("right_lat_k6", {30'd0, EN}, 32'd0);
    wait_to(k + 7);
    chk("right_lat_k7", {30'd0, EN}, 32'd1);
    wait_to(k + 9);
    set_btn(4'b0000);
    step(10);
    tap(4'b1000, 10, 10); chk("right2", {30'd0, EN}, 32'd2);
    tap(4'b1000, 10, 10); chk("right3_wrap", {30'd0, EN}, 32'd0);
    tap(4'b1000, 10, 10); chk("right4", {30'd0, EN}, 32'd1);
    tap(4'b0100, 10, 10); chk("left1", {30'd0, EN}, 32'd0);
    tap(4'b0100, 10, 10); chk("left_wrap", {30'd0, EN}, 32'd2);

    // 3. bouncing up button, then stable for 6 cycles
    u0 = cnt_up;
    for (int i = 0; i < 3; i++) begin
      set_btn(4'b0001); step(3);
      set_btn(4'b0000); step(2);
    end
    set_btn(4'b0001);
    k = cyc + 1;
    wait_to(k + 5);
    set_btn(4'b0000);
    wait_to(k + 6);
    chk("bounce_quiet", cnt_up - u0, 32'd0);
    chk("bounce_k6", {31'd0, aumento}, 32'd0);
    wait_to(k + 7);
    chk("bounce_k7", {31'd0, aumento}, 32'd1);
    step(12);
    chk("bounce_count", cnt_up - u0, 32'd1);

    // 4. exclusions
    u0 = cnt_up; d0 = cnt_dn;
    tap(4'b0011, 8, 12);
    chk("updown_aum", cnt_up - u0, 32'd0);
    chk("updown_dis", cnt_dn - d0, 32'd0);
    tap(4'b1001, 8, 12);                       // EN was 2
    chk("upright_en", {30'd0, EN}, 32'd0);
    chk("upright_aum", cnt_up - u0, 32'd0);
    ajuste_on = 1'b0;
    step(1);
    chk("off_en", {30'd0, EN}, 32'd3);
    tap(4'b0001, 8, 12);
    tap(4'b0010, 8, 12);
    tap(4'b1000, 8, 12);
    chk("off_en_hold", {30'd0, EN}, 32'd3);
    chk("off_strobes", (cnt_up - u0) + (cnt_dn - d0), 32'd0);
    ajuste_on = 1'b1;
    step(2);

    // 5. down held 40 cycles
    d0 = cnt_dn;
    tap(4'b0010, 40, 15);
`ifdef AUTOREPEAT_EN
    chk("hold_down_count", cnt_dn - d0, 32'd5);
`else
    chk("hold_down_count", cnt_dn - d0, 32'd1);
`endif

    // 6. reset while up is held; the re-debounced level must not strobe
    set_btn(4'b0001);
    step(10);
    u0 = cnt_up;
    rst = 1'b1;
    ajuste_on = 1'b0;
    #1;
    chk("rst_hold_en", {30'd0, EN}, 32'd3);
    chk("rst_hold_aum", {31'd0, aumento}, 32'd0);
    step(3);
    rst = 1'b0;
    step(12);
    chk("after_rst_en", {30'd0, EN}, 32'd3);
    ajuste_on = 1'b1;
    step(1);
    chk("reentry_en", {30'd0, EN}, 32'd0);
    step(10);
    chk("no_stale_press", cnt_up - u0, 32'd0);
    set_btn(4'b0000);
    step(10);
    tap(4'b0001, 8, 12);
    chk("fresh_press", cnt_up - u0, 32'd1);

    // 7. randomised traffic checked by the model each cycle
    lvl = 4'b0000;
    for (int b = 0; b < 4; b++) dur[b] = 0;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (dur[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          dur[b] = ($urandom_range(0, 9) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 10);
        end else begin
          dur[b] = dur[b] - 1;
        end
      end
      if (ajuste_on && $urandom_range(0, 199) == 0) ajuste_on = 1'b0;
      else if (!ajuste_on && $urandom_range(0, 19) == 0) ajuste_on = 1'b1;
      if (c == 1200) rst = 1'b1;
      if (c == 1203) rst = 1'b0;
      set_btn(lvl);
      step(1);
    end
    set_btn(4'b0000);
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
